bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly upstream of the 7-segment digit decoders. It accepts a binary value on a start strobe, produces DIGITS packed BCD nibbles plus a leading-zero blank mask, and holds both until the next conversion completes. Each nibble of `bcd_out` drives the 4-bit input of one segment decoder. Each `blank` bit lets display logic suppress leading zeros.

---
 rtl/bin2bcd_seq.sv | 135 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per
// clock. It feeds the 7-segment digit decoders directly. The BCD result and
// its leading-zero blank mask are registered. Both hold their value until the
// next conversion completes.

module bin2bcd_seq #(
    parameter int BIN_W  = 16,  // binary input width, >= 1
    parameter int DIGITS = 5    // BCD digits, 10**DIGITS > 2**BIN_W - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // The value 0 displays as a single "0", so digit 0 is never blanked.
    localparam logic [DIGITS-1:0] BLANK_ZERO = ~(DIGITS'(1));

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic               done_q, done_d;

    logic [SCR_W-1:0]   adj;      // scratch after the add-3 correction
    logic [SCR_W-1:0]   shifted;  // scratch after correction and left shift

    // Bit k is set when digit k and every more-significant digit are zero.
    function automatic logic [DIGITS-1:0] calc_blank(input logic [SCR_W-1:0] v);
        logic [DIGITS-1:0] b;
        logic              zero_above;
        b          = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (v[4*k +: 4] == 4'd0);
            b[k]       = zero_above;
        end
        return b;
    endfunction

    // Add-3 correction on every nibble >= 5, then shift in the next binary bit.
    always_comb begin
        adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end else begin
                adj[4*k +: 4] = scratch_q[4*k +: 4];
            end
        end
        shifted = (adj << 1) | SCR_W'(shift_q[BIN_W-1]);
    end

    // Next-state and datapath control for the IDLE/SHIFT machine.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_d   = shift_q << 1;
                scratch_d = shifted;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = shifted;
                    blank_d = calc_blank(shifted);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments here, so every register samples the
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            // NOTE: the working registers are cleared along with the outputs,
            // so an aborted conversion leaves no stale state behind.
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            blank_q   <= BLANK_ZERO;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign blank   = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
// Directed bench for bin2bcd_seq with the default parameters (16 bits, 5 digits).
// Expected results are queued when a conversion is started.
// A negedge monitor pops one entry on every done pulse and compares it.

module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;
    logic [4:0]  blank;

    typedef struct packed {
        logic [19:0] bcd;
        logic [4:0]  blank;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   lat;
    int   bcnt;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .blank   (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            check("done_busy_overlap", 32'(busy), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd_out", 32'(bcd_out), 32'(e.bcd));
                check("blank", 32'(blank), 32'(e.blank));
            end
        end
    end

    // Count the edges until done, starting just after the accepting edge.
    // lat stays 0 if done never arrives within the bound.
    task automatic wait_done(output int n_edges, output int n_busy);
        n_edges = 0;
        n_busy  = 0;
        for (int n = 1; n <= 40; n++) begin
            if (busy) n_busy++;
            @(posedge clk);
            #1;
            if (done) begin
                n_edges = n;
                break;
            end
        end
    endtask

    // Start one conversion and return when the done cycle is reached.
    task automatic convert(input logic [15:0] v, input logic [19:0] eb,
                           input logic [4:0] ebl, output int n_edges, output int n_busy);
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        sb.push_back({eb, ebl});
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = 16'($urandom);  // bin_in need only be stable at the accepting edge
        wait_done(n_edges, n_busy);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'h00000);
        check("rst_blank", 32'(blank), 32'(5'b11110));
        @(negedge clk);
        rst_n = 1'b1;

        // Zero input
        convert(16'd0, 20'h00000, 5'b11110, lat, bcnt);
        check("lat_zero", 32'(lat), 32'd16);

        // Full scale: busy high exactly 16 cycles, done lasts one cycle
        convert(16'd65535, 20'h65535, 5'b00000, lat, bcnt);
        check("lat_full", 32'(lat), 32'd16);
        check("busy_cycles_full", 32'(bcnt), 32'd16);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);

        // Mid-range value, then back-to-back start in the done cycle
        convert(16'd1234, 20'h01234, 5'b10000, lat, bcnt);
        check("lat_1234", 32'(lat), 32'd16);
        start  = 1'b1;
        bin_in = 16'd9;
        sb.push_back({20'h00009, 5'b11110});
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = 16'd4444;
        check("b2b_busy", 32'(busy), 32'd1);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (!done) check("hold_1234", 32'(bcd_out), 32'h01234);
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check("lat_b2b", 32'(lat), 32'd16);

        // Start while busy is ignored
        @(negedge clk);
        bin_in = 16'd500;
        start  = 1'b1;
        sb.push_back({20'h00500, 5'b11000});
        @(posedge clk);           // E0
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk); // E4
        #1;
        start  = 1'b1;
        bin_in = 16'd777;
        @(posedge clk);           // E5
        #1;
        start  = 1'b0;
        bin_in = 16'd0;
        wait_done(lat, bcnt);
        check("lat_ignore", 32'(lat), 32'd11);
        repeat (20) @(posedge clk);
        #1;
        check("ignore_idle", 32'(busy), 32'd0);
        check("ignore_hold", 32'(bcd_out), 32'h00500);

        // Reset mid-operation
        @(negedge clk);
        bin_in = 16'd4321;
        start  = 1'b1;
        @(posedge clk);           // E0
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk); // E8
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'h00000);
        check("abort_blank", 32'(blank), 32'(5'b11110));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_restart", 32'(busy), 32'd0);
        check("abort_bcd_after", 32'(bcd_out), 32'h00000);

        convert(16'd42, 20'h00042, 5'b11100, lat, bcnt);
        check("lat_42", 32'(lat), 32'd16);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
